// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: fetches sequential words from imem into a small FIFO toward decode.
// Latency: ack in cycle N -> inst_valid in cycle N+1; a new request can issue the cycle after an ack.
// Backpressure: inst_ready=0 lets the FIFO fill; requests stop once FIFO entries plus the outstanding request reach DEPTH.
//
// Ports:
//   clk, n_reset               - single clock, synchronous active-low reset
//   imem_req/imem_addr         - single outstanding read request, held until imem_ack
//   imem_ack/imem_rdata        - response strobe and data
//   inst_valid/inst_ready      - decode handshake; inst/inst_pc give the FIFO head
//   redirect/redirect_pc       - flush the FIFO and restart fetching at redirect_pc
//   stall_cycles               - only with PREFETCH_STALL_COUNT_EN: saturating count of
//                                cycles where decode was ready but nothing was valid
// Optional feature macro: PREFETCH_STALL_COUNT_EN
module inst_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        n_reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef PREFETCH_STALL_COUNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    entry_t             mem_q [DEPTH];

    logic               push;
    logic               pop;
    logic               pend_after;
    logic               issue;

    assign imem_req   = pend_q;
    assign imem_addr  = req_addr_q;
    assign inst_valid = (count_q != '0);
    assign inst       = mem_q[rd_ptr_q].word;
    assign inst_pc    = mem_q[rd_ptr_q].pc;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        pop  = inst_valid & inst_ready;
        // Acked data is only kept in RUN and when no redirect flushes it in the same cycle.
        push = (state_q == RUN) & pend_q & imem_ack & ~redirect;

        case (state_q)
            RUN:     if (redirect && pend_q && !imem_ack) state_d = DISCARD;
            DISCARD: if (imem_ack) state_d = RUN;
            default: state_d = RUN;
        endcase

        // Stray acks with no request outstanding never affect anything.
        pend_after = pend_q & ~imem_ack;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (redirect) begin
            // Flush: head catches up with tail; a concurrent pop is already handed over.
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Room is judged on post-edge occupancy, so a pop or ack frees a slot for
        // a request in the very next cycle.
        issue      = (state_d == RUN) && !pend_after && (count_d < DEPTH_C);
        pend_d     = pend_after | issue;
        req_addr_d = issue ? fetch_pc_d : req_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q    <= RUN;
            pend_q     <= 1'b0;
            req_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            req_addr_q <= req_addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push) begin
                mem_q[wr_ptr_q] <= '{word: imem_rdata, pc: req_addr_q};
            end
        end
    end

`ifdef PREFETCH_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            stall_cycles <= '0;
        end else if (inst_ready && !inst_valid && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Bench for inst_prefetch_buffer: directed scenarios plus randomized traffic vs a queue-based model.
// Latency: outputs sampled on the falling edge, inputs driven there too.
// Backpressure: inst_ready is randomized in phases so the FIFO runs both empty and full.
module tb_inst_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef PREFETCH_STALL_COUNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] m_stall;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    // Reference model: FIFO contents as a queue, the outstanding request, discard flag, next fetch address.
    ent_t        mq[$];
    logic        m_pend;
    logic        m_disc;
    logic [31:0] m_addr;
    logic [31:0] m_fetch;

    inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef PREFETCH_STALL_COUNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Drive one cycle of inputs, advance the model by the rules, then move to the next falling edge.
    task automatic step(input logic rst_n, input logic ack, input logic rdy,
                        input logic redir, input logic [31:0] rpc);
        logic pop;
        logic ack_eff;
        n_reset     = rst_n;
        imem_ack    = ack;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_rdata  = m_pend ? mem_word(m_addr) : $urandom;
        if (!rst_n) begin
            mq.delete();
            m_pend  = 1'b0;
            m_disc  = 1'b0;
            m_addr  = RESET_PC;
            m_fetch = RESET_PC;
`ifdef PREFETCH_STALL_COUNT_EN
            m_stall = '0;
`endif
        end else begin
`ifdef PREFETCH_STALL_COUNT_EN
            if (rdy && mq.size() == 0 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
            pop     = (mq.size() != 0) && rdy;
            ack_eff = m_pend && ack;
            if (pop) void'(mq.pop_front());
            if (m_disc) begin
                if (ack_eff) begin
                    m_disc = 1'b0;
                    m_pend = 1'b0;
                end
            end else if (redir) begin
                if (m_pend && !ack) m_disc = 1'b1;
                else m_pend = 1'b0;
            end else if (ack_eff) begin
                mq.push_back('{pc: m_addr, word: mem_word(m_addr)});
                m_fetch = m_addr + 32'd1;
                m_pend  = 1'b0;
            end
            if (redir) begin
                mq.delete();
                m_fetch = rpc;
            end
            if (!m_disc && !m_pend && mq.size() < DEPTH) begin
                m_pend = 1'b1;
                m_addr = m_fetch;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        step(1'b0, 1'b1, rdy, 1'b0, 32'h0);
        step(1'b0, 1'b1, rdy, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h/%h exp=0/0", inst, inst_pc); end
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin failures++; $display("FAIL first_req got=%b/%h exp=1/%h", imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(k)) begin failures++; $display("FAIL stream_req k=%0d got=%b/%h exp=1/%h", k, imem_req, imem_addr, k); end
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(k) || inst !== mem_word(32'(k))) begin
                failures++; $display("FAIL stream_inst k=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst, k, mem_word(32'(k)));
            end
        end
    endtask

    task automatic test_fill_full();
        int npush = 0;
        do_reset(1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (imem_req === 1'b1) begin
                checks++; if (imem_addr !== 32'(npush)) begin failures++; $display("FAIL full_addr got=%h exp=%h", imem_addr, npush); end
                step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
                npush++;
            end else begin
                step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            end
        end
        checks++; if (npush !== DEPTH) begin failures++; $display("FAIL full_pushes got=%0d exp=%0d", npush, DEPTH); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL full_req_idle got=%b exp=0", imem_req); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("FAIL full_head got=%b/%h exp=1/0", inst_valid, inst_pc); end
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL full_refill got=%b/%h exp=1/4", imem_req, imem_addr); end
        checks++; if (inst_pc !== 32'h1) begin failures++; $display("FAIL full_pop got=%h exp=1", inst_pc); end
    endtask

    task automatic test_delayed_ack();
        do_reset(1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
                failures++; $display("FAIL delay_hold i=%0d got=%b/%h/%b exp=1/0/0", i, imem_req, imem_addr, inst_valid);
            end
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== mem_word(32'h0)) begin
            failures++; $display("FAIL delay_push got=%b/%h/%h exp=1/0/%h", inst_valid, inst_pc, inst, mem_word(32'h0));
        end
        checks++; if (imem_addr !== 32'h1) begin failures++; $display("FAIL delay_next got=%h exp=1", imem_addr); end
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL delay_single got=%b exp=0", inst_valid); end
    endtask

    task automatic test_redirect_outstanding();
        do_reset(1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h5) begin failures++; $display("FAIL redir_setup got=%b/%h exp=1/5", imem_req, imem_addr); end
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h5 || inst_valid !== 1'b0) begin
            failures++; $display("FAIL redir_hold1 got=%b/%h/%b exp=1/5/0", imem_req, imem_addr, inst_valid);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h5) begin failures++; $display("FAIL redir_hold2 got=%b/%h exp=1/5", imem_req, imem_addr); end
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_drop got=%b exp=0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL redir_newreq got=%b/%h exp=1/100", imem_req, imem_addr); end
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== mem_word(32'h100)) begin
            failures++; $display("FAIL redir_first got=%b/%h/%h exp=1/100/%h", inst_valid, inst_pc, inst, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_with_ack();
        do_reset(1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b1 || imem_addr !== 32'h3) begin failures++; $display("FAIL rack_setup got=%b/%h exp=1/3", inst_valid, imem_addr); end
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rack_flush got=%b exp=0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL rack_req got=%b/%h exp=1/40", imem_req, imem_addr); end
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin failures++; $display("FAIL rack_first got=%b/%h exp=1/40", inst_valid, inst_pc); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        checks++; if (imem_addr !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_req got=%h exp=ffffffff", imem_addr); end
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (inst_pc !== 32'hFFFF_FFFF || imem_addr !== 32'h0) begin
            failures++; $display("FAIL wrap_next got=%h/%h exp=ffffffff/0", inst_pc, imem_addr);
        end
    endtask

`ifdef PREFETCH_STALL_COUNT_EN
    task automatic test_stall_count();
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (stall_cycles !== 16'd5) begin failures++; $display("FAIL stall_count got=%0d exp=5", stall_cycles); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (stall_cycles !== 16'd0 || imem_req !== 1'b0) begin
            failures++; $display("FAIL stall_reset got=%0d/%b exp=0/0", stall_cycles, imem_req);
        end
    endtask
`endif

    task automatic test_random();
        int          lat = 0;
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        do_reset(1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 2000; c++) begin
            checks++; if (imem_req !== m_pend) begin failures++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imem_req, m_pend); end
            if (m_pend) begin
                checks++; if (imem_addr !== m_addr) begin failures++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, m_addr); end
            end
            checks++; if (inst_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%0d", c, inst_valid, mq.size()); end
            if (mq.size() != 0) begin
                checks++; if (inst !== mq[0].word || inst_pc !== mq[0].pc) begin
                    failures++; $display("FAIL rnd_head c=%0d got=%h/%h exp=%h/%h", c, inst, inst_pc, mq[0].word, mq[0].pc);
                end
            end
`ifdef PREFETCH_STALL_COUNT_EN
            checks++; if (stall_cycles !== m_stall) begin failures++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall_cycles, m_stall); end
`endif
            if (m_pend) begin
                if (lat == 0) begin
                    ack = 1'b1;
                    lat = $urandom_range(0, 3);
                end else begin
                    ack = 1'b0;
                    lat--;
                end
            end else begin
                ack = ($urandom_range(0, 3) == 0);
            end
            if (((c / 256) % 2) == 1) rdy = ($urandom_range(0, 7) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : $urandom;
            step(1'b1, ack, rdy, redir, rpc);
        end
    endtask

    initial begin
        m_pend  = 1'b0;
        m_disc  = 1'b0;
        m_addr  = RESET_PC;
        m_fetch = RESET_PC;
`ifdef PREFETCH_STALL_COUNT_EN
        m_stall = '0;
`endif
        @(negedge clk);
        test_reset();
        test_stream();
        test_fill_full();
        test_delayed_ack();
        test_redirect_outstanding();
        test_redirect_with_ack();
        test_wrap();
`ifdef PREFETCH_STALL_COUNT_EN
        test_stall_count();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
